bus_trace_uart: RTL and testbench
=================================

BUS_TRACE_UART -- requirements
Module: bus_trace_uart

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, bus address width; it SHALL be a multiple of 4.
REQ-002 The block SHALL have parameter DATA_W, default 8, bus data width; it SHALL be a multiple of 4.
REQ-003 The block SHALL have parameter DEPTH, default 16, number of trace FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-004 The block SHALL have parameter WIN_LO, default 16'h2000, inclusive lower capture address.
REQ-005 The block SHALL have parameter WIN_HI, default 16'h7FFF, inclusive upper capture address.
REQ-006 The block SHALL have parameter MODE, default 2'b11; bit0 enables read capture and bit1 enables write capture.
REQ-007 The block SHALL have parameter IO_SPACE, default 0; 0 qualifies captures with bus_mreq_n and 1 with bus_iorq_n.
REQ-008 The block SHALL have ports: clk in 1, system clock; greset in 1, asynchronous active-low reset.
REQ-009 The block SHALL have ports: bus_a in ADDR_W, bus address; bus_d in DATA_W, bus data as sampled from the pad buffer.
REQ-010 The block SHALL have ports: bus_mreq_n, bus_iorq_n, bus_rd_n and bus_wr_n, each in 1, active-low Z80 strobes that are asynchronous to clk.
REQ-011 The block SHALL have port enable in 1; while it is 0, no new captures occur and draining continues.
REQ-012 The block SHALL have ports: tx_req out 1, character valid; tx_data out 8, ASCII character; tx_ready in 1, UART accept.
REQ-013 The block SHALL have ports: fifo_level out clog2(DEPTH)+1, occupied entries; overflow out 1, sticky drop flag; drop_count out 8, saturating drop count; busy out 1, formatter not idle.

Function
REQ-014 All bus inputs SHALL pass through a 2-flop synchronizer; capture logic SHALL use only synchronized values.
REQ-015 A capture event SHALL occur on the first cycle in which synchronized bus_rd_n or bus_wr_n is 1 after being 0 on the previous cycle, while the space strobe and address were valid on the previous cycle.
REQ-016 A capture event SHALL require all of: enable=1, the MODE bit set for the cycle type, the space strobe low, and WIN_LO <= address <= WIN_HI, using the previous-cycle synchronized address and data.
REQ-017 Each entry SHALL be {is_write, address, data}.
REQ-018 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-019 Otherwise a push SHALL be dropped: overflow is set and drop_count increments, saturating at 8'hFF.
REQ-020 The formatter FSM SHALL have states IDLE, POP, EMIT and NEXT.
- IDLE->POP when the FIFO is not empty.
- POP latches the head entry and goes to EMIT.
- EMIT holds tx_req=1 with the current character; a character transfers on a cycle with tx_req=1 and tx_ready=1.
- NEXT advances the character index; after the last character it returns to IDLE, otherwise to EMIT.
REQ-021 Each line SHALL be: "W" or "R", space, ADDR_W/4 uppercase hex digits (MSB first), space, DATA_W/4 hex digits, 8'h0D, 8'h0A; with the defaults this is 11 characters.
REQ-022 tx_data SHALL remain stable while tx_req=1 and tx_ready=0.
REQ-023 Latency from a capture event to the first tx_req SHALL be at most 4 cycles when the FIFO is empty and the FSM is IDLE.
REQ-024 overflow and drop_count SHALL clear only on reset.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH, and fifo_level SHALL equal DEPTH when the FIFO is full.

Reset
REQ-026 greset=0 SHALL asynchronously clear the following, abandoning any partial line:
- tx_req=0, tx_data=0;
- FIFO empty, fifo_level=0;
- overflow=0, drop_count=0, busy=0;
- FSM=IDLE;
- synchronizers to strobe-inactive (1).
REQ-027 Deassertion of greset SHALL produce no spurious capture event.

Structure
REQ-028 Package bus_trace_pkg SHALL hold the FSM state encoding, the hex-to-ASCII function, and the line-length constant (2 + ADDR_W/4 + 1 + DATA_W/4 + 2).
REQ-029 The FIFO SHALL be a separate sub-module, trace_fifo, parametrised by width and DEPTH.

Verification
REQ-030 Write to 16'h2345 with data 8'hA5 and tx_ready held at 1 -> "W 2345 A5\r\n" appears on tx_data, with the first tx_req within 4 cycles of the capture event.
REQ-031 Reads at 16'h1FFF, 16'h2000, 16'h7FFF and 16'h8000 -> exactly two lines are emitted, for 2000 and 7FFF.
REQ-032 With tx_ready=0, capture 18 cycles (DEPTH=16) -> fifo_level=16, overflow=1, drop_count=2; then release tx_ready -> 16 lines are emitted in capture order.
REQ-033 With tx_ready toggling every cycle during a line -> each character is transferred exactly once, and tx_data is stable while stalled.
REQ-034 Assert greset mid-line after 5 characters -> tx_req=0 immediately; after release, no output occurs until a new capture.
REQ-035 MODE=2'b10 with IO_SPACE=1, one I/O read and one I/O write at 16'h00C0 -> only "W 00C0 xx" is emitted.

Source files
------------

// File: rtl/bus_trace_pkg.sv
// rtl/bus_trace_pkg.sv - shared types and helpers for the bus trace formatter
//
// Purpose: formatter state encoding, nibble-to-ASCII conversion and the
// trace line length. No ports.
package bus_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_EMIT = 2'd2,
    ST_NEXT = 2'd3
  } fmt_state_t;

  // "W"/"R", space, address digits, space, data digits, CR, LF
  function automatic int line_len(int addr_w, int data_w);
    return 2 + addr_w / 4 + 1 + data_w / 4 + 2;
  endfunction

  localparam int LINE_LEN = line_len(16, 8);

  // Uppercase hex: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
  function automatic logic [7:0] hex_to_ascii(logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - trace entry FIFO with same-cycle push-when-full-and-pop
//
// Purpose: stores captured bus entries until the formatter retires them.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_push, i_data     push request and entry
//   i_pop              retire the head entry (ignored when empty)
//   o_head             current head entry (valid when not empty)
//   o_empty, o_full    occupancy flags
//   o_level            occupied entries, 0..DEPTH
//   o_drop             push request that could not be accepted this cycle
module trace_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_level,
  output logic             o_drop
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_level   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_drop    = i_push & ~w_do_push;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_trace_uart.sv
// rtl/bus_trace_uart.sv - Z80 bus cycle tracer emitting ASCII lines to a UART
//
// Purpose: captures qualifying read/write cycles inside an address window and
// prints each as "W|R AAAA DD\r\n" through a character handshake.
// Ports:
//   clk, greset                    clock, asynchronous active-low reset
//   bus_a, bus_d                   bus address and data (asynchronous)
//   bus_mreq_n, bus_iorq_n,
//   bus_rd_n, bus_wr_n             active-low bus strobes (asynchronous)
//   enable                         allow new captures
//   tx_req, tx_data, tx_ready      character out, accepted when tx_req & tx_ready
//   fifo_level                     queued entries (includes line being printed)
//   overflow, drop_count           sticky drop flag, saturating drop counter
//   busy                           formatter not idle
module bus_trace_uart
  import bus_trace_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 8,
  parameter int              DEPTH    = 16,
  parameter logic [ADDR_W-1:0] WIN_LO = ADDR_W'(16'h2000),
  parameter logic [ADDR_W-1:0] WIN_HI = ADDR_W'(16'h7FFF),
  parameter logic [1:0]      MODE     = 2'b11,
  parameter int              IO_SPACE = 0,
  localparam int             LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              greset,
  input  logic [ADDR_W-1:0] bus_a,
  input  logic [DATA_W-1:0] bus_d,
  input  logic              bus_mreq_n,
  input  logic              bus_iorq_n,
  input  logic              bus_rd_n,
  input  logic              bus_wr_n,
  input  logic              enable,
  output logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic [7:0]        drop_count,
  output logic              busy
);

  localparam int NA    = ADDR_W / 4;
  localparam int ND    = DATA_W / 4;
  localparam int LEN   = line_len(ADDR_W, DATA_W);
  localparam int IDX_W = $clog2(LEN);
  localparam int EW    = 1 + ADDR_W + DATA_W;

  // Strobe vector order: {mreq, iorq, rd, wr}
  logic [3:0]        r_s1_strb, r_s2_strb;
  logic [ADDR_W-1:0] r_s1_a, r_s2_a, r_p_a;
  logic [DATA_W-1:0] r_s1_d, r_s2_d, r_p_d;
  logic              r_p_sp_n, r_p_rd_n, r_p_wr_n;

  logic              w_sp_n;
  logic              w_qual;
  logic              w_cap_wr, w_cap_rd, w_push;
  logic [EW-1:0]     w_entry;
  logic [EW-1:0]     w_head;
  logic              w_empty, w_full, w_drop, w_pop;

  fmt_state_t        r_state, w_next;
  logic [EW-1:0]     r_entry;
  logic [IDX_W-1:0]  r_idx;
  logic              w_last;
  logic [7:0]        w_char;
  logic              w_ent_wr;
  logic [ADDR_W-1:0] w_ent_a;
  logic [DATA_W-1:0] w_ent_d;
  logic [7:0]        r_drop_cnt;
  logic              r_overflow;

  // Strobes reset to inactive and the previous-cycle copies too, so leaving
  // reset can never look like a strobe release.
  always_ff @(posedge clk or negedge greset) begin
    if (!greset) begin
      r_s1_strb <= 4'hF;
      r_s2_strb <= 4'hF;
      r_s1_a    <= '0;
      r_s2_a    <= '0;
      r_s1_d    <= '0;
      r_s2_d    <= '0;
      r_p_a     <= '0;
      r_p_d     <= '0;
      r_p_sp_n  <= 1'b1;
      r_p_rd_n  <= 1'b1;
      r_p_wr_n  <= 1'b1;
    end else begin
      r_s1_strb <= {bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n};
      r_s2_strb <= r_s1_strb;
      r_s1_a    <= bus_a;
      r_s2_a    <= r_s1_a;
      r_s1_d    <= bus_d;
      r_s2_d    <= r_s1_d;
      r_p_a     <= r_s2_a;
      r_p_d     <= r_s2_d;
      r_p_sp_n  <= w_sp_n;
      r_p_rd_n  <= r_s2_strb[1];
      r_p_wr_n  <= r_s2_strb[0];
    end
  end

  assign w_sp_n = (IO_SPACE != 0) ? r_s2_strb[2] : r_s2_strb[3];

  // Capture on strobe release; address/data/space come from the last cycle
  // the strobe was still asserted.
  assign w_qual   = enable & ~r_p_sp_n & (r_p_a >= WIN_LO) & (r_p_a <= WIN_HI);
  assign w_cap_wr = w_qual & MODE[1] & r_s2_strb[0] & ~r_p_wr_n;
  assign w_cap_rd = w_qual & MODE[0] & r_s2_strb[1] & ~r_p_rd_n;
  assign w_push   = w_cap_wr | w_cap_rd;
  assign w_entry  = {w_cap_wr, r_p_a, r_p_d};

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (greset),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (fifo_level),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk or negedge greset) begin
    if (!greset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'h01;
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_cnt;

  // The head is only copied in POP; it leaves the FIFO when its line is
  // complete, so fifo_level counts the line currently being printed.
  assign w_last = (r_idx == IDX_W'(LEN - 1));

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) w_next = ST_POP;
      ST_POP:  w_next = ST_EMIT;
      ST_EMIT: if (tx_ready) w_next = ST_NEXT;
      ST_NEXT: begin
        if (w_last) begin
          w_next = ST_IDLE;
          w_pop  = 1'b1;
        end else begin
          w_next = ST_EMIT;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge greset) begin
    if (!greset) begin
      r_state <= ST_IDLE;
      r_entry <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_POP) begin
        r_entry <= w_head;
        r_idx   <= '0;
      end
      if (r_state == ST_NEXT) begin
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  assign w_ent_wr = r_entry[EW-1];
  assign w_ent_a  = r_entry[EW-2 -: ADDR_W];
  assign w_ent_d  = r_entry[DATA_W-1:0];

  always_comb begin
    int         i;
    int         sh;
    logic [3:0] nib;
    w_char = 8'h00;
    nib    = 4'h0;
    sh     = 0;
    i      = int'(r_idx);
    if (i == 0) begin
      w_char = w_ent_wr ? 8'h57 : 8'h52;
    end else if (i == 1 || i == 2 + NA) begin
      w_char = 8'h20;
    end else if (i < 2 + NA) begin
      sh     = 4 * (NA + 1 - i);
      nib    = 4'(w_ent_a >> sh);
      w_char = hex_to_ascii(nib);
    end else if (i < 3 + NA + ND) begin
      sh     = 4 * (NA + ND + 2 - i);
      nib    = 4'(w_ent_d >> sh);
      w_char = hex_to_ascii(nib);
    end else if (i == 3 + NA + ND) begin
      w_char = 8'h0D;
    end else begin
      w_char = 8'h0A;
    end
  end

  assign tx_req  = (r_state == ST_EMIT);
  assign tx_data = tx_req ? w_char : 8'h00;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bus_trace_uart.sv
// tb/tb_bus_trace_uart.sv - self-checking bench for bus_trace_uart
module tb_bus_trace_uart;

  logic        clk = 1'b0;
  logic        greset;
  logic [15:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n;
  logic        enable, en2;
  logic        tx_req, tx_ready, overflow, busy;
  logic [7:0]  tx_data, drop_count;
  logic [4:0]  fifo_level;
  logic        tx_req2, overflow2, busy2;
  logic [7:0]  tx_data2, drop_count2;
  logic [4:0]  fifo_level2;

  always #5 clk = ~clk;

  bus_trace_uart dut (
    .clk(clk), .greset(greset), .bus_a(bus_a), .bus_d(bus_d),
    .bus_mreq_n(bus_mreq_n), .bus_iorq_n(bus_iorq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .enable(enable), .tx_req(tx_req), .tx_data(tx_data), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count), .busy(busy)
  );

  bus_trace_uart #(
    .WIN_LO(16'h0080), .WIN_HI(16'h0FFF), .MODE(2'b10), .IO_SPACE(1)
  ) dut_io (
    .clk(clk), .greset(greset), .bus_a(bus_a), .bus_d(bus_d),
    .bus_mreq_n(bus_mreq_n), .bus_iorq_n(bus_iorq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .enable(en2), .tx_req(tx_req2), .tx_data(tx_data2), .tx_ready(1'b1),
    .fifo_level(fifo_level2), .overflow(overflow2), .drop_count(drop_count2), .busy(busy2)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    bit          en;
    bit          cap;
  } vec_t;

  int    n_cmp = 0;
  int    n_fail = 0;
  bq_t   rx_q, rx2_q, exp_q;
  int    ready_mode = 0;
  logic  ready_val = 1'b1;
  logic  prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  string hx = "0123456789ABCDEF";

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: text of one trace line, straight from the line format
  task automatic fmt_line(input bit wr, input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back(wr ? 8'h57 : 8'h52);
    exp_q.push_back(8'h20);
    for (int k = 3; k >= 0; k--) exp_q.push_back(hx[a[4*k +: 4]]);
    exp_q.push_back(8'h20);
    for (int k = 1; k >= 0; k--) exp_q.push_back(hx[d[4*k +: 4]]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic check_rx(input string name, input bq_t got);
    int bad;
    bad = -1;
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (bad < 0 && got[i] !== exp_q[i]) bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_data: char %0d got %0h, want %0h", name, bad, got[bad], exp_q[bad]);
    end
    exp_q.delete();
  endtask

  task automatic bus_cycle(input bit wr, input logic [15:0] a, input logic [7:0] d, input bit io);
    tick();
    bus_a = a;
    bus_d = d;
    if (io) bus_iorq_n = 1'b0; else bus_mreq_n = 1'b0;
    tick();
    if (wr) bus_wr_n = 1'b0; else bus_rd_n = 1'b0;
    repeat (3) tick();
    bus_wr_n = 1'b1;
    bus_rd_n = 1'b1;
    repeat (3) tick();
    bus_mreq_n = 1'b1;
    bus_iorq_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int k;
    repeat (4) tick();
    k = 0;
    while ((busy || fifo_level != 0) && k < 3000) begin
      tick();
      k++;
    end
    chk({name, "_drain"}, {31'd0, busy || fifo_level != 0}, 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = ready_val;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!greset) begin
      prev_stall = 1'b0;
    end else begin
      if (tx_req && prev_stall) begin
        n_cmp++;
        if (tx_data !== prev_data) begin
          n_fail++;
          $display("FAIL stall_stable: got %0h, want %0h", tx_data, prev_data);
        end
      end
      if (tx_req && tx_ready) rx_q.push_back(tx_data);
      if (tx_req2) rx2_q.push_back(tx_data2);
      prev_stall = tx_req && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[8];
    int          lat;
    int          k;
    bit          wr, en;
    logic [15:0] a;
    logic [7:0]  d;

    tbl[0] = '{1'b1, 16'h2345, 8'hA5, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 16'h1FFF, 8'h11, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'h2000, 8'h22, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 16'h7FFF, 8'h33, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 16'h8000, 8'h44, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 16'h4000, 8'h5C, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 16'h7FFF, 8'h0F, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 16'h0000, 8'hFF, 1'b1, 1'b0};

    greset = 1'b0;
    bus_a = 16'h0000; bus_d = 8'h00;
    bus_mreq_n = 1'b1; bus_iorq_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
    enable = 1'b1; en2 = 1'b0; tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drops", {24'd0, drop_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    greset = 1'b1;
    repeat (3) tick();

    // Table of single cycles: window edges, disable, write/read
    for (int i = 0; i < 8; i++) begin
      enable = tbl[i].en;
      bus_cycle(tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0);
      enable = 1'b1;
      wait_idle($sformatf("vec%0d", i));
      if (tbl[i].cap) fmt_line(tbl[i].wr, tbl[i].a, tbl[i].d);
      check_rx($sformatf("vec%0d", i), rx_q);
      rx_q.delete();
    end

    // Capture-to-first-character latency
    tick();
    bus_a = 16'h2345; bus_d = 8'hA5; bus_mreq_n = 1'b0;
    tick();
    bus_wr_n = 1'b0;
    repeat (3) tick();
    bus_wr_n = 1'b1;
    lat = 0;
    while (!tx_req && lat < 20) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat > 6) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles after release, want <= 6", lat);
    end
    bus_mreq_n = 1'b1;
    wait_idle("lat");
    fmt_line(1'b1, 16'h2345, 8'hA5);
    check_rx("lat", rx_q);
    rx_q.delete();

    // tx_ready toggling every cycle
    ready_mode = 1;
    bus_cycle(1'b1, 16'h3ABC, 8'h7E, 1'b0);
    wait_idle("toggle");
    fmt_line(1'b1, 16'h3ABC, 8'h7E);
    check_rx("toggle", rx_q);
    rx_q.delete();

    // Random cycles, random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 12; i++) begin
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom);
        1:       a = 16'h1FFF + 16'($urandom_range(0, 2));
        2:       a = 16'h7FFE + 16'($urandom_range(0, 2));
        default: a = 16'h2000 + 16'($urandom_range(0, 16'h5FFF));
      endcase
      d = 8'($urandom);
      en = ($urandom_range(0, 3) != 0);
      enable = en;
      bus_cycle(wr, a, d, 1'b0);
      if (en && a >= 16'h2000 && a <= 16'h7FFF) fmt_line(wr, a, d);
    end
    enable = 1'b1;
    ready_mode = 0;
    ready_val = 1'b1;
    wait_idle("random");
    check_rx("random", rx_q);
    rx_q.delete();
    chk("random_overflow", {31'd0, overflow}, 32'd0);

    // Overflow: 18 captures with the UART stalled
    ready_val = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 18; i++) begin
      bus_cycle(1'b1, 16'h2000 + 16'(i), 8'(i * 7), 1'b0);
      if (i < 16) fmt_line(1'b1, 16'h2000 + 16'(i), 8'(i * 7));
    end
    repeat (4) tick();
    chk("ovf_level", {27'd0, fifo_level}, 32'd16);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_drops", {24'd0, drop_count}, 32'd2);
    chk("ovf_tx_req", {31'd0, tx_req}, 32'd1);
    ready_val = 1'b1;
    wait_idle("ovf");
    check_rx("ovf", rx_q);
    rx_q.delete();
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_drops_kept", {24'd0, drop_count}, 32'd2);

    // Reset in the middle of a line
    bus_cycle(1'b0, 16'h6001, 8'h99, 1'b0);
    k = 0;
    while (rx_q.size() < 5 && k < 100) begin
      tick();
      k++;
    end
    chk("mid_reached5", rx_q.size(), 32'd5);
    tick();
    greset = 1'b0;
    #1;
    chk("mid_tx_req", {31'd0, tx_req}, 32'd0);
    chk("mid_tx_data", {24'd0, tx_data}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_level", {27'd0, fifo_level}, 32'd0);
    chk("mid_overflow", {31'd0, overflow}, 32'd0);
    chk("mid_drops", {24'd0, drop_count}, 32'd0);
    repeat (3) tick();
    greset = 1'b1;
    repeat (60) tick();
    chk("mid_quiet", rx_q.size(), 32'd5);
    rx_q.delete();

    // I/O space, write-only capture on the second instance
    en2 = 1'b1;
    bus_cycle(1'b0, 16'h00C0, 8'h3C, 1'b1);
    bus_cycle(1'b1, 16'h00C0, 8'h5A, 1'b1);
    k = 0;
    repeat (4) tick();
    while ((busy2 || fifo_level2 != 0) && k < 500) begin
      tick();
      k++;
    end
    chk("io_drain", {31'd0, busy2 || fifo_level2 != 0}, 32'd0);
    fmt_line(1'b1, 16'h00C0, 8'h5A);
    check_rx("io", rx2_q);
    chk("io_main_silent", rx_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
